// File: rtl/tpu_pkg.sv
`default_nettype none
//============================================================================
// Module      : tpu_pkg
// Description : Shared definitions for the systolic-array front end:
//               lane data width, default array size, the feeder state
//               encoding and the drain-length helper.
// Revision    : 1.0 - initial release
//============================================================================
package tpu_pkg;

  localparam int DATA_W    = 8;
  localparam int DEFAULT_N = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_e;

  // Advances needed after the last vector so the deepest skew lane and the
  // array diagonal are fully flushed.
  function automatic int DRAIN_LEN(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_skew_line.sv
`default_nettype none
//============================================================================
// Module      : skew_line
// Description : DEPTH-stage shift register that only moves on an advance
//               enable. DEPTH = 0 degenerates to a wire.
// Ports       : clk, reset (sync, active-high), adv_i (shift enable),
//               din_i (lane input), dout_o (lane delayed by DEPTH advances)
// Revision    : 1.0 - initial release
//============================================================================
module skew_line
  import tpu_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock, reset and enable have no role in a zero-depth lane.
    logic unused_w;
    assign unused_w = ^{clk, reset, adv_i};
    assign dout_o   = din_i;
  end else begin : g_shift
    logic [DEPTH-1:0][DW-1:0] sr_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sr_q <= '0;
      end else if (adv_i) begin
        sr_q[0] <= din_i;
        for (int k = 1; k < DEPTH; k++) begin
          sr_q[k] <= sr_q[k-1];
        end
      end
    end

    assign dout_o = sr_q[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
//============================================================================
// Module      : systolic_feeder
// Description : Edge driver for an N x N weight-stationary PE array. Loads
//               N weight rows down the weight chain, then streams
//               activation vectors into the left edge with lane i delayed
//               by i advances, then drains the array with zeros.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start, signed_in, num_vectors - job launch (IDLE only)
//               w_valid/w_ready/w_data - weight row handshake
//               a_valid/a_ready/a_data - activation vector handshake
//               weight_out, weight_ctr - top-row weights + load enable
//               sys_out, systolic_ctr, fma_ctr - skewed left-edge data
//               signed_num, busy, done - job status
//               stall_cycles   - only with SYSTOLIC_FEEDER_STALL_CNT_EN
// Options     : SYSTOLIC_FEEDER_STALL_CNT_EN adds a saturating counter of
//               STREAM cycles spent waiting on a_valid.
// Revision    : 1.0 - initial release
//============================================================================
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DW    = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_in,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [N*DW-1:0]   w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [N*DW-1:0]   a_data,
  output logic [N*DW-1:0]   weight_out,
  output logic              weight_ctr,
  output logic [N*DW-1:0]   sys_out,
  output logic              systolic_ctr,
  output logic              fma_ctr,
  output logic              signed_num,
  output logic              busy,
  output logic              done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int DRAIN_CYC = DRAIN_LEN(N);
  localparam int WC_W      = $clog2(N + 1);
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, acc_cnt_q;
  logic [WC_W-1:0]  w_cnt_q;
  logic [DC_W-1:0]  drain_cnt_q;
  logic             signed_q, weight_ctr_q, sys_ctr_q;
  logic [N*DW-1:0]  weight_out_q, sys_out_q, sys_next_w;
  logic             drain_w, start_w, w_hs_w, a_hs_w, adv_w;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD_W;
      LOAD_W: if (w_hs_w && (w_cnt_q == WC_W'(N - 1)))
                state_d = (num_vec_q == '0) ? DONE : STREAM;
      STREAM: if (a_hs_w && (acc_cnt_q == num_vec_q - CNT_W'(1)))
                state_d = DRAIN;
      DRAIN:  if (drain_cnt_q == DC_W'(DRAIN_CYC - 1)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    drain_w = 1'b0;
    case (state_q)
      IDLE:   busy    = 1'b0;
      LOAD_W: w_ready = 1'b1;
      STREAM: a_ready = (acc_cnt_q < num_vec_q);
      DRAIN:  drain_w = 1'b1;
      DONE:   done    = 1'b1;
      default: busy   = 1'b0;
    endcase
  end

  assign start_w = start && (state_q == IDLE);
  assign w_hs_w  = w_valid && w_ready;
  assign a_hs_w  = a_valid && a_ready;
  // The whole array moves together: on an accepted vector or a drain cycle.
  assign adv_w   = a_hs_w || drain_w;

  // ---------------- per-lane diagonal skew ----------------
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] inj_w;
    assign inj_w = drain_w ? '0 : a_data[i*DW +: DW];

    skew_line #(
      .DEPTH (i),
      .DW    (DW)
    ) u_skew (
      .clk    (clk),
      .reset  (reset),
      .adv_i  (adv_w),
      .din_i  (inj_w),
      .dout_o (sys_next_w[i*DW +: DW])
    );
  end

  // ---------------- datapath and counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      num_vec_q    <= '0;
      acc_cnt_q    <= '0;
      w_cnt_q      <= '0;
      drain_cnt_q  <= '0;
      signed_q     <= 1'b0;
      weight_ctr_q <= 1'b0;
      sys_ctr_q    <= 1'b0;
      weight_out_q <= '0;
      sys_out_q    <= '0;
    end else begin
      if (start_w) begin
        signed_q    <= signed_in;
        num_vec_q   <= num_vectors;
        acc_cnt_q   <= '0;
        w_cnt_q     <= '0;
        drain_cnt_q <= '0;
      end
      if (w_hs_w) begin
        weight_out_q <= w_data;
        w_cnt_q      <= w_cnt_q + WC_W'(1);
      end
      if (a_hs_w)  acc_cnt_q   <= acc_cnt_q + CNT_W'(1);
      if (drain_w) drain_cnt_q <= drain_cnt_q + DC_W'(1);
      // Enables are registered so they line up with the registered data.
      weight_ctr_q <= w_hs_w;
      sys_ctr_q    <= adv_w;
      if (adv_w) sys_out_q <= sys_next_w;
      if (state_q == DONE) begin
        weight_out_q <= '0;
        sys_out_q    <= '0;
        weight_ctr_q <= 1'b0;
        sys_ctr_q    <= 1'b0;
      end
    end
  end

  assign weight_out   = weight_out_q;
  assign weight_ctr   = weight_ctr_q;
  assign sys_out      = sys_out_q;
  assign systolic_ctr = sys_ctr_q;
  assign fma_ctr      = sys_ctr_q;
  assign signed_num   = signed_q;

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_w) begin
      stall_q <= '0;
    end else if ((state_q == STREAM) && !a_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire
